comb_filter_multimode: RTL and testbench
========================================

Name: comb_filter_multimode

Overview:
Parametrised successor to the fixed-delay feedforward comb. One block provides feedforward (y[n] = x[n] + g·x[n−D]) and feedback (y[n] = x[n] + g·y[n−D]) combs on signed audio samples. Delay D and gain g are set at run time, and sample flow is gated by a valid strobe. It sits in the audio effects chain between the sample source (48 kHz strobe domain, system clk) and downstream effects/DAC formatter.

Parameters:
DATA_W, 16, sample width, signed two's complement
MAX_DELAY, 1024, delay-line depth in samples; power of two, ≥4
ADDR_W, $clog2(MAX_DELAY), delay/pointer width (derived, not overridden)
GAIN_W, 8, gain width, signed Q1.(GAIN_W−1), range −1.0 … +(1−2^−(GAIN_W−1))

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  audio_in/delay/gain/mode sampled this cycle
audio_in  input  DATA_W  signed input sample
delay  input  ADDR_W  delay D in samples
gain  input  GAIN_W  signed Q1.(GAIN_W−1) gain g
mode  input  1  0 = feedforward, 1 = feedback
out_valid  output  1  one-cycle pulse, audio_out valid
audio_out  output  DATA_W  signed output sample, held between pulses
clip  output  1  high with out_valid when that output saturated

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: out_valid=0, audio_out=0, clip=0, write pointer=0, fill count=0, stored mode=0. Delay RAM is not cleared. History is masked by the fill count.
- Latency: exactly 1 cycle; out_valid registered from in_valid. Back-to-back in_valid every cycle is supported. No backpressure.
- Inputs are ignored when in_valid=0; no state changes.
- Effective delay De = max(delay,1). delay=0 behaves as 1.
- Delay line: circular buffer of MAX_DELAY words, asynchronous read.
  - Read address = wr_ptr − De (mod MAX_DELAY).
  - The write at wr_ptr occurs on the same in_valid edge, then wr_ptr increments and wraps MAX_DELAY−1 → 0.
- Fill count: saturating counter 0 … MAX_DELAY, +1 per in_valid. If fill < De, the delayed term d = 0 (pre-history is silence).
- Arithmetic:
  - p = d × gain is a full-precision signed product.
  - Arithmetic shift right by GAIN_W−1 (floor).
  - s = audio_in + p, computed at DATA_W+2 bits.
  - audio_out = s saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. clip=1 iff saturation occurred.
- Written word:
  - mode 0: audio_in.
  - mode 1: the saturated audio_out, so the feedback loop stays bounded.
- Mode change: an in_valid with mode ≠ stored mode resets fill to 0 before processing, so d=0 for that sample. That sample's word is written and counted (fill becomes 1), and the stored mode updates.
- Delay or gain change: takes effect on the same in_valid. History is kept; no flush.
- Async reset mid-stream: outputs drop immediately; the first post-reset sample sees d=0.

Test Plan:
- Impulse FF: mode0, delay=4, gain=0x40 (+0.5); x = 16'h4000 then zeros → outputs 4000,0,0,0,2000,0,0… with out_valid 1 cycle after each in_valid.
- Impulse FB: mode1, delay=3, gain=0x40; x = 4000 then zeros → 4000,0,0,2000,0,0,1000,0,0,0800… (decaying every 3rd sample).
- Saturation: mode0, delay=1, gain=0x7F; x = 7FFF, 7FFF → out 7FFF clip=0, then 7FFF clip=1. With negative gain 0x80 on x = 8000, 8000 → 8000, 0000 clip=0.
- Pre-history/wrap: MAX_DELAY=16, delay=15, gain=0x40. After reset, 15 ramp samples give pure passthrough (d=0). Running 40 samples checks wrap-around against the golden model. delay=0 gives results identical to delay=1.
- Mode switch mid-stream: run FF with constant 1000 (out 1800 steady, gain 0.5, D=2). Switch to FB → first FB output = 1000 (history masked), then FB sequence 1000,1800,1800+… per model.
- Reset/gaps: random in_valid gaps (30% duty) give outputs equal to the gap-free model. Asserting rst_n low mid-stream clears out_valid/audio_out/clip asynchronously, and the first post-reset sample has d=0.

Source files
------------

// File: rtl/comb_filter_multimode.sv
// Multimode comb filter: feedforward (y = x + g*x[n-D]) or feedback
// (y = x + g*y[n-D]) on signed samples, with run-time delay, gain and mode.
// One-cycle latency from in_valid to out_valid; history is masked by a
// saturating fill count so pre-history and mode switches read as silence.
module comb_filter_multimode #(
   parameter int DATA_W    = 16,
   parameter int MAX_DELAY = 1024,
   parameter int GAIN_W    = 8,
   localparam int ADDR_W   = $clog2(MAX_DELAY)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] audio_in,
   input  logic [ADDR_W-1:0] delay,
   input  logic [GAIN_W-1:0] gain,
   input  logic              mode,
   output logic              out_valid,
   output logic [DATA_W-1:0] audio_out,
   output logic              clip
);

   localparam int SUM_W  = DATA_W + 2;
   localparam int PROD_W = DATA_W + GAIN_W;
   localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(MAX_DELAY);
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (DATA_W - 1)));

   logic [DATA_W-1:0] mem [MAX_DELAY];

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   fill;
   logic              stored_mode;

   logic [ADDR_W-1:0]        eff_delay;
   logic [ADDR_W-1:0]        rd_addr;
   logic [ADDR_W:0]          fill_eff;
   logic [ADDR_W:0]          fill_next;
   logic                     mode_change;
   logic                     history_ok;
   logic signed [DATA_W-1:0] sample;
   logic signed [GAIN_W-1:0] gain_s;
   logic signed [DATA_W-1:0] delayed;
   logic signed [PROD_W-1:0] product;
   logic signed [SUM_W-1:0]  sum;
   logic [DATA_W-1:0]        sat_word;
   logic                     sat_flag;
   logic [DATA_W-1:0]        write_word;

   // Datapath: delayed tap lookup, gain multiply, floor shift, add and saturate.
   // A mode change clears the effective fill so that sample sees no history.
   always_comb begin
      eff_delay   = delay;
      mode_change = 1'b0;
      fill_eff    = fill;
      rd_addr     = '0;
      history_ok  = 1'b0;
      sample      = audio_in;
      gain_s      = gain;
      delayed     = '0;
      product     = '0;
      sum         = '0;
      sat_word    = '0;
      sat_flag    = 1'b0;
      fill_next   = fill;
      write_word  = audio_in;

      if (delay == '0) begin
         eff_delay = ADDR_W'(1);
      end
      mode_change = (mode != stored_mode);
      if (mode_change) begin
         fill_eff = '0;
      end
      rd_addr    = wr_ptr - eff_delay;
      history_ok = (fill_eff >= {1'b0, eff_delay});
      if (history_ok) begin
         delayed = mem[rd_addr];
      end

      product = PROD_W'(delayed) * PROD_W'(gain_s);
      sum     = SUM_W'(sample) + SUM_W'(product >>> (GAIN_W - 1));

      if (sum > SAT_MAX) begin
         sat_word = SAT_MAX[DATA_W-1:0];
         sat_flag = 1'b1;
      end else if (sum < SAT_MIN) begin
         sat_word = SAT_MIN[DATA_W-1:0];
         sat_flag = 1'b1;
      end else begin
         sat_word = sum[DATA_W-1:0];
      end

      if (fill_eff == FILL_MAX) begin
         fill_next = FILL_MAX;
      end else begin
         fill_next = fill_eff + (ADDR_W + 1)'(1);
      end

      write_word = mode ? sat_word : audio_in;
   end

   // Control and output registers; everything advances only on in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         audio_out   <= '0;
         clip        <= 1'b0;
         wr_ptr      <= '0;
         fill        <= '0;
         stored_mode <= 1'b0;
      end else begin
         out_valid <= in_valid;
         clip      <= in_valid & sat_flag;
         if (in_valid) begin
            audio_out   <= sat_word;
            wr_ptr      <= wr_ptr + ADDR_W'(1);
            fill        <= fill_next;
            stored_mode <= mode;
         end
      end
   end

   // Delay-line RAM write; contents survive reset because fill masks them.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         mem[wr_ptr] <= write_word;
      end
   end

endmodule

// File: tb/tb_comb_filter_multimode.sv
// Directed bench for comb_filter_multimode with a 16-deep delay line.
// Hand-computed vectors cover impulses, saturation, delay=0 and mode switch;
// a small reference model covers the wrap-around and gapped-valid runs.
module tb_comb_filter_multimode;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] audio_in;
   logic [3:0]  delay;
   logic [7:0]  gain;
   logic        mode;
   logic        out_valid;
   logic [15:0] audio_out;
   logic        clip;

   int vectors;
   int miscompares;

   int          m_hist [16];
   int          m_wp;
   int          m_fill;
   logic        m_mode;
   logic [15:0] m_exp;
   logic        m_clip;

   comb_filter_multimode #(
      .DATA_W(16),
      .MAX_DELAY(16),
      .GAIN_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .audio_in(audio_in),
      .delay(delay),
      .gain(gain),
      .mode(mode),
      .out_valid(out_valid),
      .audio_out(audio_out),
      .clip(clip)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic modelReset();
      m_wp   = 0;
      m_fill = 0;
      m_mode = 1'b0;
   endtask

   // Reference model of one accepted sample, written from the behaviour rules.
   task automatic modelStep(input logic [15:0] x, input logic [3:0] dly,
                            input logic [7:0] g, input logic m);
      int de, dv, xs, gs, s, sat;
      de = (dly == 4'd0) ? 1 : int'(dly);
      if (m != m_mode) m_fill = 0;
      dv = (m_fill < de) ? 0 : m_hist[(m_wp - de + 16) % 16];
      xs = int'($signed(x));
      gs = int'($signed(g));
      s  = xs + ((dv * gs) >>> 7);
      m_clip = 1'b0;
      if (s > 32767) begin
         sat = 32767;
         m_clip = 1'b1;
      end else if (s < -32768) begin
         sat = -32768;
         m_clip = 1'b1;
      end else begin
         sat = s;
      end
      m_exp = 16'(sat);
      m_hist[m_wp] = m ? sat : xs;
      m_wp = (m_wp + 1) % 16;
      if (m_fill < 16) m_fill = m_fill + 1;
      m_mode = m;
   endtask

   task automatic doReset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #3;
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Present one sample for one clock, then sample outputs 1 ns after the edge.
   task automatic applyStimulus(input logic [15:0] x, input logic [3:0] dly,
                                input logic [7:0] g, input logic m);
      audio_in = x;
      delay    = dly;
      gain     = g;
      mode     = m;
      in_valid = 1'b1;
      modelStep(x, dly, g, m);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idleCycle();
      in_valid = 1'b0;
      audio_in = 16'h5A5A;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] exp_audio,
                              input logic exp_clip);
      vectors++;
      assert (out_valid === 1'b1) else begin
         miscompares++;
         $error("[TB] FAIL %s out_valid got %b want 1", tag, out_valid);
      end
      vectors++;
      assert (audio_out === exp_audio) else begin
         miscompares++;
         $error("[TB] FAIL %s audio_out got %h want %h", tag, audio_out, exp_audio);
      end
      vectors++;
      assert (clip === exp_clip) else begin
         miscompares++;
         $error("[TB] FAIL %s clip got %b want %b", tag, clip, exp_clip);
      end
   endtask

   task automatic checkIdle(input string tag, input logic [15:0] held);
      vectors++;
      assert (out_valid === 1'b0) else begin
         miscompares++;
         $error("[TB] FAIL %s out_valid got %b want 0", tag, out_valid);
      end
      vectors++;
      assert (audio_out === held) else begin
         miscompares++;
         $error("[TB] FAIL %s held audio_out got %h want %h", tag, audio_out, held);
      end
   endtask

   // Directed sequence.
   initial begin
      logic [15:0] ff_exp [8];
      logic [15:0] fb_exp [10];
      logic [15:0] sw_exp [10];
      logic [15:0] last;
      int          gap;

      vectors     = 0;
      miscompares = 0;
      audio_in    = '0;
      delay       = '0;
      gain        = '0;
      mode        = 1'b0;
      modelReset();
      for (int i = 0; i < 16; i++) m_hist[i] = 0;

      doReset();
      checkIdle("reset", 16'h0000);
      vectors++;
      assert (clip === 1'b0) else begin
         miscompares++;
         $error("[TB] FAIL reset clip got %b want 0", clip);
      end

      // Feedforward impulse, D=4, g=+0.5.
      ff_exp = '{16'h4000, 16'h0000, 16'h0000, 16'h0000,
                 16'h2000, 16'h0000, 16'h0000, 16'h0000};
      for (int i = 0; i < 8; i++) begin
         applyStimulus((i == 0) ? 16'h4000 : 16'h0000, 4'd4, 8'h40, 1'b0);
         checkOutput($sformatf("ff_impulse[%0d]", i), ff_exp[i], 1'b0);
      end
      idleCycle();
      checkIdle("ff_idle", 16'h0000);

      // Feedback impulse, D=3, g=+0.5: decays every third sample.
      doReset();
      fb_exp = '{16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000,
                 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h0800};
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i == 0) ? 16'h4000 : 16'h0000, 4'd3, 8'h40, 1'b1);
         checkOutput($sformatf("fb_impulse[%0d]", i), fb_exp[i], 1'b0);
      end

      // Positive saturation with near-unity gain.
      doReset();
      applyStimulus(16'h7FFF, 4'd1, 8'h7F, 1'b0);
      checkOutput("sat_pos0", 16'h7FFF, 1'b0);
      applyStimulus(16'h7FFF, 4'd1, 8'h7F, 1'b0);
      checkOutput("sat_pos1", 16'h7FFF, 1'b1);

      // Gain of -1.0 on full-scale negative input lands exactly on zero.
      doReset();
      applyStimulus(16'h8000, 4'd1, 8'h80, 1'b0);
      checkOutput("neg_gain0", 16'h8000, 1'b0);
      applyStimulus(16'h8000, 4'd1, 8'h80, 1'b0);
      checkOutput("neg_gain1", 16'h0000, 1'b0);

      // delay=0 acts as delay=1.
      doReset();
      applyStimulus(16'h0100, 4'd0, 8'h40, 1'b0);
      checkOutput("d0_a", 16'h0100, 1'b0);
      applyStimulus(16'h0200, 4'd0, 8'h40, 1'b0);
      checkOutput("d0_b", 16'h0280, 1'b0);
      applyStimulus(16'h0300, 4'd1, 8'h40, 1'b0);
      checkOutput("d1_c", 16'h0400, 1'b0);

      // Pre-history and wrap: D=15 on a 16-deep line, 40 ramp samples.
      doReset();
      for (int i = 0; i < 40; i++) begin
         applyStimulus(16'((i + 1) * 256), 4'd15, 8'h40, 1'b0);
         if (i < 15) begin
            checkOutput($sformatf("prehist[%0d]", i), 16'((i + 1) * 256), 1'b0);
         end else begin
            checkOutput($sformatf("wrap[%0d]", i), m_exp, m_clip);
         end
      end

      // Mode switch mid-stream: FF steady at 1800, then FB restarts masked.
      doReset();
      sw_exp = '{16'h1000, 16'h1000, 16'h1800, 16'h1800,
                 16'h1000, 16'h1000, 16'h1800, 16'h1800, 16'h1C00, 16'h1C00};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(16'h1000, 4'd2, 8'h40, (i >= 4) ? 1'b1 : 1'b0);
         checkOutput($sformatf("mode_sw[%0d]", i), sw_exp[i], 1'b0);
      end

      // Random gaps on in_valid (~30% duty) must not disturb the result.
      doReset();
      last = 16'h0000;
      for (int i = 0; i < 24; i++) begin
         gap = 0;
         while (gap < 6 && $urandom_range(0, 99) >= 30) begin
            idleCycle();
            checkIdle($sformatf("gap_idle[%0d]", i), last);
            gap++;
         end
         applyStimulus(16'($urandom_range(0, 65535)), 4'd3, 8'hA0,
                       (i >= 12) ? 1'b1 : 1'b0);
         checkOutput($sformatf("gap[%0d]", i), m_exp, m_clip);
         last = m_exp;
      end

      // Asynchronous reset mid-stream, then first sample sees no history.
      doReset();
      applyStimulus(16'h2000, 4'd1, 8'h40, 1'b0);
      checkOutput("areset_pre0", 16'h2000, 1'b0);
      applyStimulus(16'h2000, 4'd1, 8'h40, 1'b0);
      checkOutput("areset_pre1", 16'h3000, 1'b0);
      rst_n = 1'b0;
      #2;
      checkIdle("areset_async", 16'h0000);
      vectors++;
      assert (clip === 1'b0) else begin
         miscompares++;
         $error("[TB] FAIL areset_async clip got %b want 0", clip);
      end
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(16'h0400, 4'd1, 8'h40, 1'b0);
      checkOutput("areset_post", 16'h0400, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
